// File: rtl/led_pattern_pkg.sv
// Shared types for the LED pattern engine: channel modes and the channel-index width helper.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_FOLLOW = 2'd2,
    MODE_PULSE  = 2'd3
  } mode_e;

  function automatic int ch_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/led_channel.sv
// One LED channel: mode/half/cnt/led state machine plus the follow_in synchroniser.
module led_channel
  import led_pattern_pkg::*;
#(
  parameter int CNT_W    = 26,
  parameter int DEF_HALF = 10000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  mode_e            mode,
  input  logic [CNT_W-1:0] half,
  input  logic             sync,
  input  logic             follow,
  output logic             led,
  output logic             done
);

  mode_e            mode_q;
  logic [CNT_W-1:0] half_q, cnt_q, cnt_d, eff_half;
  logic             led_q, done_q, meta_q, term;

  always_comb begin
    eff_half = (half_q == '0) ? CNT_W'(1) : half_q;
    term     = (cnt_q == eff_half - CNT_W'(1));
    cnt_d    = cnt_q + CNT_W'(1);
  end

  // In FOLLOW mode led_q doubles as the second synchroniser stage behind meta_q.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= MODE_OFF;
      half_q <= CNT_W'(DEF_HALF);
      cnt_q  <= '0;
      led_q  <= 1'b0;
      done_q <= 1'b0;
      meta_q <= 1'b0;
    end else begin
      meta_q <= follow;
      done_q <= 1'b0;
      if (load) begin
        mode_q <= mode;
        half_q <= half;
        cnt_q  <= '0;
        case (mode)
          MODE_OFF:    led_q <= 1'b0;
          MODE_FOLLOW: led_q <= meta_q;
          default:     led_q <= 1'b1;
        endcase
      end else begin
        case (mode_q)
          MODE_BLINK: begin
            if (sync) begin
              led_q <= 1'b1;
              cnt_q <= '0;
            end else if (term) begin
              led_q <= ~led_q;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          MODE_PULSE: begin
            if (term) begin
              led_q  <= 1'b0;
              cnt_q  <= '0;
              mode_q <= MODE_OFF;
              done_q <= 1'b1;
            end else begin
              cnt_q <= cnt_d;
            end
          end
          MODE_FOLLOW: begin
            led_q <= meta_q;
            cnt_q <= '0;
          end
          default: begin
            led_q <= 1'b0;
            cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign led  = led_q;
  assign done = done_q;

endmodule

// File: rtl/led_pattern_engine.sv
// N-channel LED pattern generator: config decode, ack/err registers and the channel array.
module led_pattern_engine
  import led_pattern_pkg::*;
#(
  parameter  int N_CH     = 3,
  parameter  int CNT_W    = 26,
  parameter  int DEF_HALF = 10000000,
  localparam int CH_W     = ch_w(N_CH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ack,
  output logic             cfg_err,
  input  logic             sync,
  input  logic [N_CH-1:0]  follow_in,
  output logic [N_CH-1:0]  led,
  output logic [N_CH-1:0]  pulse_done
);

  localparam logic [CH_W:0] N_CH_L = (CH_W+1)'(N_CH);

  logic            ch_ok;
  logic            ack_q, err_q;
  logic [N_CH-1:0] load;

  assign ch_ok = ({1'b0, cfg_ch} < N_CH_L);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign load[g] = cfg_we && (cfg_ch == CH_W'(g));

    led_channel #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .load   (load[g]),
      .mode   (mode_e'(cfg_mode)),
      .half   (cfg_half),
      .sync   (sync),
      .follow (follow_in[g]),
      .led    (led[g]),
      .done   (pulse_done[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= cfg_we && ch_ok;
      err_q <= cfg_we && !ch_ok;
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised N-channel LED pattern generator: the next generation of the board's parallel blink logic. Each channel runs its own independent state machine in one of four modes: off, free-running blink, follow an external level, or single timed pulse. Half-periods and modes are runtime-programmable through a single-cycle config port, so one instance replaces the fixed, hard-coded per-LED blink circuits. It also provides a global phase re-sync and per-channel pulse-done status. It sits between board-level control logic and the LED pins.

## Interface

Parameters:
- N_CH, 3: number of channels/LEDs; 1..16.
- CNT_W, 26: half-period counter width; unsigned.
- DEF_HALF, 10000000: half-period loaded into every channel at reset; must fit in CNT_W.

Ports (one clock; reset is synchronous and active-low):
- clk, in, 1: system clock.
- rst, in, 1: synchronous reset, active-low; sampled on posedge clk.
- cfg_we, in, 1: config write strobe; one write per cycle.
- cfg_ch, in, CH_W: target channel; CH_W = max(1, clog2(N_CH)).
- cfg_mode, in, 2: 0 OFF, 1 BLINK, 2 FOLLOW, 3 PULSE.
- cfg_half, in, CNT_W: half-period in cycles; 0 is treated as 1.
- cfg_ack, out, 1: one-cycle pulse the cycle after an accepted write.
- cfg_err, out, 1: one-cycle pulse the cycle after a write with cfg_ch >= N_CH.
- sync, in, 1: global phase restart of all BLINK channels.
- follow_in, in, N_CH: asynchronous level inputs for FOLLOW mode.
- led, out, N_CH: registered LED drive, active-high.
- pulse_done, out, N_CH: one-cycle pulse per channel when a PULSE completes.

## Operation

- Per-channel registers: mode (2b), half (CNT_W), cnt (CNT_W), led bit, 2-flop synchroniser for follow_in.
- Accepted write (cfg_we=1, cfg_ch<N_CH) at edge k loads mode and half, clears cnt, and sets the channel's first output at k:
  - OFF: led=0.
  - BLINK and PULSE: led=1.
  - FOLLOW: led takes the current synchroniser output.
  - A write to an active channel restarts it; no glitch beyond that restart.
- BLINK: each cycle, if cnt == eff_half-1 then toggle led and set cnt=0, else cnt+1. eff_half = max(half,1). led is high for eff_half cycles, then low for eff_half cycles.
- PULSE: led=1 for eff_half cycles. At the terminal count: led=0, mode becomes OFF, pulse_done=1 for one cycle.
- FOLLOW: led follows follow_in through two flops; cnt is held at 0.
- OFF: led=0, cnt=0.
- sync=1 at edge k: every BLINK channel sets led=1 and cnt=0. OFF, FOLLOW and PULSE channels are unaffected.
- Simultaneous cfg_we and sync: the addressed channel takes the write; sync applies to all other channels.
- Invalid channel write: no state change; cfg_err pulses, cfg_ack does not.
- Reset (rst=0 at an edge), including mid-pulse or mid-blink:
  - Every channel: mode OFF, half=DEF_HALF, cnt=0, led=0, synchronisers=0.
  - Outputs: cfg_ack=0, cfg_err=0, pulse_done=0.
  - An aborted pulse does not raise pulse_done.

## Timing

- All outputs are registered; there is no combinational path from input to output.
- Config write latency: led reflects the new mode in the cycle after the write edge. cfg_ack or cfg_err is asserted in that same cycle.
- BLINK period: 2·eff_half cycles. With half=0 or 1, led toggles every cycle.
- PULSE: led high for exactly eff_half cycles. pulse_done is asserted in the first cycle led is low.
- FOLLOW latency: a follow_in change settled before edge k appears on led after edge k+1.
- Counter compare is unsigned. cnt never exceeds eff_half-1, so there is no wrap.

## Structure

- Package led_pattern_pkg holds:
  - The mode enum: MODE_OFF, MODE_BLINK, MODE_FOLLOW, MODE_PULSE.
  - A CH_W helper function.
- Sub-module led_channel holds one channel: mode/half/cnt/led FSM plus the follow synchroniser. It has the inputs load, mode, half, sync, follow, and the outputs led and done.
- The top level does only the following:
  - Generate-instantiates N_CH channels.
  - Decodes cfg_ch into per-channel load strobes.
  - Registers cfg_ack and cfg_err.
- Target size is 150–250 lines in total.

## Test plan

- Reset: hold rst=0 for 3 cycles while cfg_we=1 → led=000, pulse_done=000, cfg_ack=0. After release, all channels are OFF with half=DEF_HALF.
- BLINK: write ch0 mode=1 half=4 → cfg_ack pulses next cycle. led[0] runs 1111 0000 for 3 full periods (period 8). half=0 on ch0 → led[0] toggles every cycle.
- PULSE mid-operation: write ch1 mode=3 half=5 → led[1] high for exactly 5 cycles, then pulse_done[1] asserted for 1 cycle and led[1] stays 0.
  - Repeat, asserting rst=0 at cycle 3 → no pulse_done.
- FOLLOW: write ch2 mode=2, toggle follow_in[2] 0→1→0 with 6-cycle spacing → led[2] mirrors each transition with 2-cycle latency.
- sync: ch0 BLINK half=3, ch1 BLINK half=6, ch2 FOLLOW. Pulse sync mid-phase → led[0] and led[1] both 1 next cycle and fall after 3 and 6 cycles respectively; led[2] is undisturbed.
  - In a separate run, assert cfg_we to ch0 and sync in the same cycle → ch0 takes the new config and ch1 re-syncs.
- Bad address: N_CH=3, write cfg_ch=3 → cfg_err is a 1-cycle pulse, cfg_ack=0, and all channel states are unchanged.
